mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_DSTREAK, default 4, max consecutive data grants while an instruction request waits (range 1-15).
REQ-002 Clock  input  1  system clock; all state changes on its rising edge.
REQ-003 nReset  input  1  reset; synchronous and active-low.
REQ-004 IReq  input  1  instruction fetch request.
REQ-005 IAddr  input  16  fetch byte address.
REQ-006 IData  output  32  fetched word, valid when IReady=1.
REQ-007 IReady  output  1  one-cycle fetch completion pulse.
REQ-008 DReq / DWrite  input  1 / 1  data request / 1=store, 0=load.
REQ-009 DAddr  input  16  data byte address.
REQ-010 DWData  input  32  store data.
REQ-011 DWriteL / DWriteR  input  1 / 1  unaligned store-left / store-right qualifiers.
REQ-012 DRData  output  32  load data, valid when DReady=1.
REQ-013 DReady  output  1  one-cycle data completion pulse.
REQ-014 MemAddr, MemWData  output  16, 32  shared memory address and write data.
REQ-015 MemReadEn, MemWriteEn, MemWriteL, MemWriteR  output  1 each  memory strobes.
REQ-016 MemRData  input  32  memory read data, valid the cycle after MemReadEn.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_I, WAIT_D; arbitration SHALL occur only in IDLE.
REQ-018 In IDLE with a winning request, the memory command SHALL be driven combinationally that same cycle (cycle N).
REQ-019 Priority: data over instruction, except when IReq=1 and the streak counter equals MAX_DSTREAK, in which case the instruction SHALL win.
REQ-020 Streak counter (4 bits): +1 on each data grant while IReq=1; cleared on an instruction grant or any cycle IReq=0; saturates at MAX_DSTREAK.
REQ-021 Fetch: cycle N MemReadEn=1, MemAddr=IAddr, next state WAIT_I; cycle N+1 MemRData registered into IData; cycle N+2 IReady=1, state IDLE.
REQ-022 Load: as REQ-021 via WAIT_D, with MemAddr=DAddr, DRData captured, DReady=1 at N+2.
REQ-023 Store: cycle N MemWriteEn=1, MemAddr=DAddr, MemWData=DWData, MemWriteL/R=DWriteL/R; state stays IDLE; DReady=1 at N+1.
REQ-024 Outside a command cycle, all Mem* strobes SHALL be 0; MemAddr/MemWData SHALL hold their last driven value.
REQ-025 In WAIT_I/WAIT_D no new command SHALL issue; requests SHALL be held pending.
REQ-026 IData/DRData SHALL hold their last captured value until the next capture.
REQ-027 A request withdrawn before grant SHALL be dropped silently; a request withdrawn after grant SHALL still complete with its Ready pulse.
REQ-028 A request asserted in the same cycle as its Ready pulse SHALL count as a new request and may be granted that cycle (IDLE).
REQ-029 Back-to-back reads SHALL achieve 1 transaction per 2 cycles; back-to-back stores 1 per cycle.
REQ-030 MemReadEn and MemWriteEn SHALL never be 1 simultaneously; at most one Ready pulse per transaction.

Reset
REQ-031 nReset=0 at a rising edge SHALL force state IDLE, streak counter 0, IReady=DReady=0, IData=DRData=0, MemAddr=0, MemWData=0, and all Mem* strobes 0.
REQ-032 Reset during WAIT_I/WAIT_D SHALL abandon the transaction with no Ready pulse; arbitration resumes the first cycle with nReset=1.

Verification
REQ-033 Fetch IAddr=0x0010, memory returns 0x8C220004 -> MemReadEn at N, IReady=1 with IData=0x8C220004 at N+2.
REQ-034 IReq and DReq (load 0x0100) asserted together -> data granted first, DReady at N+2; fetch issued at N+2, IReady at N+4.
REQ-035 DReq held with continuous stores and IReq=1, MAX_DSTREAK=4 -> exactly 4 store grants, then fetch granted on the 5th arbitration.
REQ-036 Store DAddr=0x0200, DWData=0xDEADBEEF, DWriteL=1 -> MemWriteEn=1, MemWriteL=1, MemWriteR=0 at N; DReady at N+1; no MemReadEn.
REQ-037 nReset=0 in WAIT_D -> no DReady, all outputs 0 next cycle; a new fetch after release completes normally.
REQ-038 IReq pulsed for one cycle while WAIT_D is active -> no fetch issued, no IReady.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter for an instruction port and a data port.
// Handshake: a request (IReq/DReq) is sampled in IDLE. The winning command
// goes out combinationally that cycle. Completion is a single-cycle Ready
// pulse. A request that is dropped before it is granted is ignored.
// Reads complete two cycles after grant. Stores complete one cycle after grant.
module mem_arbiter #(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        IReq,
    input  logic [15:0] IAddr,
    output logic [31:0] IData,
    output logic        IReady,
    input  logic        DReq,
    input  logic        DWrite,
    input  logic [15:0] DAddr,
    input  logic [31:0] DWData,
    input  logic        DWriteL,
    input  logic        DWriteR,
    output logic [31:0] DRData,
    output logic        DReady,
    output logic [15:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        MemReadEn,
    output logic        MemWriteEn,
    output logic        MemWriteL,
    output logic        MemWriteR,
    input  logic [31:0] MemRData,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] idata_q, idata_d;
    logic [31:0] drdata_q, drdata_d;
    logic        iready_q, iready_d;
    logic        dready_q, dready_d;

    logic        arb_ok;
    logic        grant_d;
    logic        grant_i;

    // Arbitration: data wins unless a waiting fetch has been starved for the full streak.
    always_comb begin
        arb_ok  = nReset && (state_q == IDLE);
        grant_d = arb_ok && DReq && !(IReq && (streak_q == STREAK_MAX));
        grant_i = arb_ok && IReq && !grant_d;
    end

    // Memory command is driven in the grant cycle; address and write data hold otherwise.
    always_comb begin
        MemReadEn  = grant_i || (grant_d && !DWrite);
        MemWriteEn = grant_d && DWrite;
        MemWriteL  = grant_d && DWrite && DWriteL;
        MemWriteR  = grant_d && DWrite && DWriteR;
        MemAddr    = grant_i ? IAddr : (grant_d ? DAddr : addr_q);
        MemWData   = (grant_d && DWrite) ? DWData : wdata_q;
    end

    // Next-state, capture and streak logic.
    always_comb begin
        state_d  = state_q;
        idata_d  = idata_q;
        drdata_d = drdata_q;
        iready_d = 1'b0;
        dready_d = 1'b0;
        addr_d   = MemAddr;
        wdata_d  = MemWData;
        streak_d = streak_q;

        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d = WAIT_I;
                end else if (grant_d) begin
                    if (DWrite) begin
                        dready_d = 1'b1;
                    end else begin
                        state_d = WAIT_D;
                    end
                end
            end
            WAIT_I: begin
                idata_d  = MemRData;
                iready_d = 1'b1;
                state_d  = IDLE;
            end
            WAIT_D: begin
                drdata_d = MemRData;
                dready_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!IReq || grant_i) begin
            streak_d = 4'd0;
        end else if (grant_d && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q  <= IDLE;
            streak_q <= 4'd0;
            addr_q   <= 16'd0;
            wdata_q  <= 32'd0;
            idata_q  <= 32'd0;
            drdata_q <= 32'd0;
            iready_q <= 1'b0;
            dready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            idata_q  <= idata_d;
            drdata_q <= drdata_d;
            iready_q <= iready_d;
            dready_q <= dready_d;
        end
    end

    assign IData     = idata_q;
    assign DRData    = drdata_q;
    assign IReady    = iready_q;
    assign DReady    = dready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a simple read-data memory model.
module tb_mem_arbiter;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        IReq;
    logic [15:0] IAddr;
    logic [31:0] IData;
    logic        IReady;
    logic        DReq;
    logic        DWrite;
    logic [15:0] DAddr;
    logic [31:0] DWData;
    logic        DWriteL;
    logic        DWriteR;
    logic [31:0] DRData;
    logic        DReady;
    logic [15:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemReadEn;
    logic        MemWriteEn;
    logic        MemWriteL;
    logic        MemWriteR;
    logic [31:0] MemRData = 32'd0;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT_I = 2'd1;
    localparam logic [1:0] S_WAIT_D = 2'd2;

    mem_arbiter #(.MAX_DSTREAK(4)) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .IReq       (IReq),
        .IAddr      (IAddr),
        .IData      (IData),
        .IReady     (IReady),
        .DReq       (DReq),
        .DWrite     (DWrite),
        .DAddr      (DAddr),
        .DWData     (DWData),
        .DWriteL    (DWriteL),
        .DWriteR    (DWriteR),
        .DRData     (DRData),
        .DReady     (DReady),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemReadEn  (MemReadEn),
        .MemWriteEn (MemWriteEn),
        .MemWriteL  (MemWriteL),
        .MemWriteR  (MemWriteR),
        .MemRData   (MemRData),
        .dbg_state  (dbg_state)
    );

    // Clock generation.
    always #5 Clock = ~Clock;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a == 16'h0010) return 32'h8C22_0004;
        return {16'hA5A5, a};
    endfunction

    // Memory model: read data appears the cycle after MemReadEn.
    always @(posedge Clock) begin
        if (MemReadEn) MemRData <= mem_word(MemAddr);
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        nReset = 1'b0; IReq = 1'b0; IAddr = 16'd0;
        DReq = 1'b0; DWrite = 1'b0; DAddr = 16'd0; DWData = 32'd0;
        DWriteL = 1'b0; DWriteR = 1'b0;
        step(); step();

        // Reset state
        chk("rst_iready", 32'(IReady), 32'd0);
        chk("rst_dready", 32'(DReady), 32'd0);
        chk("rst_idata", IData, 32'd0);
        chk("rst_drdata", DRData, 32'd0);
        chk("rst_memaddr", 32'(MemAddr), 32'd0);
        chk("rst_memwdata", MemWData, 32'd0);
        chk("rst_strobes", 32'({MemReadEn, MemWriteEn, MemWriteL, MemWriteR}), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));

        // Plain fetch from 0x0010
        nReset = 1'b1;
        IReq = 1'b1; IAddr = 16'h0010;
        #1;
        chk("f1_rden_n", 32'(MemReadEn), 32'd1);
        chk("f1_addr_n", 32'(MemAddr), 32'h0010);
        chk("f1_wren_n", 32'(MemWriteEn), 32'd0);
        step();
        IReq = 1'b0;
        chk("f1_rden_n1", 32'(MemReadEn), 32'd0);
        chk("f1_state_n1", 32'(dbg_state), 32'(S_WAIT_I));
        chk("f1_iready_n1", 32'(IReady), 32'd0);
        step();
        chk("f1_iready_n2", 32'(IReady), 32'd1);
        chk("f1_idata_n2", IData, 32'h8C22_0004);
        chk("f1_addr_hold", 32'(MemAddr), 32'h0010);
        step();
        chk("f1_iready_n3", 32'(IReady), 32'd0);
        chk("f1_idata_hold", IData, 32'h8C22_0004);

        // Simultaneous fetch and load: load first
        IReq = 1'b1; IAddr = 16'h0020;
        DReq = 1'b1; DWrite = 1'b0; DAddr = 16'h0100;
        #1;
        chk("p_rden_n", 32'(MemReadEn), 32'd1);
        chk("p_addr_n", 32'(MemAddr), 32'h0100);
        step();
        DReq = 1'b0;
        chk("p_state_n1", 32'(dbg_state), 32'(S_WAIT_D));
        chk("p_rden_n1", 32'(MemReadEn), 32'd0);
        step();
        chk("p_dready_n2", 32'(DReady), 32'd1);
        chk("p_drdata_n2", DRData, 32'hA5A5_0100);
        chk("p_fetch_rden_n2", 32'(MemReadEn), 32'd1);
        chk("p_fetch_addr_n2", 32'(MemAddr), 32'h0020);
        step();
        IReq = 1'b0;
        chk("p_dready_n3", 32'(DReady), 32'd0);
        chk("p_iready_n3", 32'(IReady), 32'd0);
        step();
        chk("p_iready_n4", 32'(IReady), 32'd1);
        chk("p_idata_n4", IData, 32'hA5A5_0020);

        // Store with store-left qualifier
        DReq = 1'b1; DWrite = 1'b1; DAddr = 16'h0200; DWData = 32'hDEAD_BEEF;
        DWriteL = 1'b1; DWriteR = 1'b0;
        #1;
        chk("st_wren", 32'(MemWriteEn), 32'd1);
        chk("st_wl", 32'(MemWriteL), 32'd1);
        chk("st_wr", 32'(MemWriteR), 32'd0);
        chk("st_rden", 32'(MemReadEn), 32'd0);
        chk("st_addr", 32'(MemAddr), 32'h0200);
        chk("st_wdata", MemWData, 32'hDEAD_BEEF);
        step();
        DReq = 1'b0; DWriteL = 1'b0; DWData = 32'd0;
        #1;
        chk("st_dready_n1", 32'(DReady), 32'd1);
        chk("st_wren_n1", 32'(MemWriteEn), 32'd0);
        chk("st_wdata_hold", MemWData, 32'hDEAD_BEEF);
        chk("st_state_n1", 32'(dbg_state), 32'(S_IDLE));
        step();
        chk("st_dready_n2", 32'(DReady), 32'd0);

        // Starvation limit: four stores then the fetch
        IReq = 1'b1; IAddr = 16'h0030;
        DReq = 1'b1; DWrite = 1'b1; DWData = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            DAddr = 16'h0300 + 16'(k);
            #1;
            chk($sformatf("sk_wren_%0d", k), 32'(MemWriteEn), 32'd1);
            chk($sformatf("sk_addr_%0d", k), 32'(MemAddr), 32'h0300 + 32'(k));
            step();
        end
        chk("sk_fetch_rden", 32'(MemReadEn), 32'd1);
        chk("sk_fetch_wren", 32'(MemWriteEn), 32'd0);
        chk("sk_fetch_addr", 32'(MemAddr), 32'h0030);
        chk("sk_dready_last", 32'(DReady), 32'd1);
        step();
        IReq = 1'b0; DReq = 1'b0;
        step();
        chk("sk_iready", 32'(IReady), 32'd1);
        chk("sk_idata", IData, 32'hA5A5_0030);

        // One-cycle fetch pulse during WAIT_D is dropped
        DReq = 1'b1; DWrite = 1'b0; DAddr = 16'h0400;
        step();
        DReq = 1'b0; IReq = 1'b1; IAddr = 16'h0040;
        #1;
        chk("drop_state", 32'(dbg_state), 32'(S_WAIT_D));
        chk("drop_rden_wait", 32'(MemReadEn), 32'd0);
        step();
        IReq = 1'b0;
        #1;
        chk("drop_dready", 32'(DReady), 32'd1);
        chk("drop_drdata", DRData, 32'hA5A5_0400);
        chk("drop_rden", 32'(MemReadEn), 32'd0);
        step();
        chk("drop_iready_1", 32'(IReady), 32'd0);
        step();
        chk("drop_iready_2", 32'(IReady), 32'd0);
        chk("drop_state_idle", 32'(dbg_state), 32'(S_IDLE));

        // Reset in WAIT_D abandons the load
        DReq = 1'b1; DWrite = 1'b0; DAddr = 16'h0500;
        step();
        DReq = 1'b0;
        chk("rw_state", 32'(dbg_state), 32'(S_WAIT_D));
        nReset = 1'b0;
        step();
        chk("rw_dready", 32'(DReady), 32'd0);
        chk("rw_drdata", DRData, 32'd0);
        chk("rw_idata", IData, 32'd0);
        chk("rw_memaddr", 32'(MemAddr), 32'd0);
        chk("rw_memwdata", MemWData, 32'd0);
        chk("rw_state_idle", 32'(dbg_state), 32'(S_IDLE));
        nReset = 1'b1;
        IReq = 1'b1; IAddr = 16'h0010;
        #1;
        chk("rw_fetch_rden", 32'(MemReadEn), 32'd1);
        step();
        IReq = 1'b0;
        chk("rw_dready_n1", 32'(DReady), 32'd0);
        step();
        chk("rw_iready", 32'(IReady), 32'd1);
        chk("rw_idata2", IData, 32'h8C22_0004);
        chk("rw_dready_n2", 32'(DReady), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
